// File: rtl/i2s_tx_serializer_pkg.sv
// i2s_tx_serializer_pkg: shared audio constants and the stereo sample type
package i2s_tx_serializer_pkg;
    localparam int I2S_SLOT_W     = 32;
    localparam int AUDIO_SAMPLE_W = 24;
    typedef struct packed {
        logic [AUDIO_SAMPLE_W-1:0] left;
        logic [AUDIO_SAMPLE_W-1:0] right;
    } stereo_sample_t;
endpackage

// File: rtl/i2s_tx_serializer_bck.sv
// i2s_bck_gen: divides the master clock into the I2S bit clock
//   clk_i  : audio master clock
//   rst_i  : asynchronous active-high reset
//   bck_o  : bit clock, toggles every BCK_DIV clk_i cycles
//   fall_o : high in the clk_i cycle whose edge drives bck_o low
module i2s_bck_gen #(
    parameter int BCK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bck_o,
    output logic fall_o
);
    localparam int DW = BCK_DIV > 1 ? $clog2(BCK_DIV) : 1;
    logic [DW-1:0] div_q, div_d;
    logic          bck_q, bck_d, tc;
    always_comb begin
        tc    = div_q == DW'(BCK_DIV - 1);
        div_d = tc ? '0 : div_q + 1'b1;
        bck_d = bck_q ^ tc;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q <= '0;
            bck_q <= 1'b0;
        end else begin
            div_q <= div_d;
            bck_q <= bck_d;
        end
    end
    assign bck_o  = bck_q;
    assign fall_o = tc & bck_q;
endmodule

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: buffers stereo PCM pairs and sends them as Philips I2S
//   AMCLK_i, ARST           : master clock, asynchronous active-high reset
//   APSDATA_LEFT/RIGHT_i    : two's complement samples, qualified by APDATA_VALID_i
//   downsample_2x_i         : accept only every second valid pair
//   I2S_BCK, I2S_WS, I2S_DATA : I2S bit clock, word select (0 = left), data MSB first
//   UNDERRUN_o, OVERRUN_o   : one-cycle flags for empty-buffer frame start / overwritten pair
module i2s_tx_serializer
    import i2s_tx_serializer_pkg::*;
#(
    parameter int SAMPLE_W = AUDIO_SAMPLE_W,
    parameter int SLOT_W   = I2S_SLOT_W,
    parameter int BCK_DIV  = 4
) (
    input  logic                AMCLK_i,
    input  logic                ARST,
    input  logic [SAMPLE_W-1:0] APSDATA_LEFT_i,
    input  logic [SAMPLE_W-1:0] APSDATA_RIGHT_i,
    input  logic                APDATA_VALID_i,
    input  logic                downsample_2x_i,
    output logic                I2S_BCK,
    output logic                I2S_WS,
    output logic                I2S_DATA,
    output logic                UNDERRUN_o,
    output logic                OVERRUN_o
);
    localparam int FRAME = 2 * SLOT_W;
    // one spare bit so that slot arithmetic never aliases into valid bit positions
    localparam int BW = $clog2(FRAME) + 1;
    localparam logic [SAMPLE_W-1:0] MSB = SAMPLE_W'(1) << (SAMPLE_W - 1);
    logic                fall, accept, load;
    logic [BW-1:0]       b_q, b_d, rb;
    logic [SAMPLE_W-1:0] buf_l_q, buf_l_d, buf_r_q, buf_r_d;
    logic [SAMPLE_W-1:0] rep_l_q, rep_l_d, rep_r_q, rep_r_d;
    logic                full_q, full_d, phase_q, phase_d;
    logic                ws_q, ws_d, data_q, data_d, und_q, und_d, ovr_q, ovr_d;
    i2s_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck (
        .clk_i (AMCLK_i),
        .rst_i (ARST),
        .bck_o (I2S_BCK),
        .fall_o(fall)
    );
    always_comb begin
        accept  = APDATA_VALID_i & ~(downsample_2x_i & phase_q);
        phase_d = downsample_2x_i & (phase_q ^ APDATA_VALID_i);
        load    = fall & (b_q == BW'(FRAME - 1));
        b_d     = fall ? (load ? '0 : b_q + 1'b1) : b_q;
        // the repeat register is the frame source; it only changes on a load with a full buffer
        rep_l_d = load & full_q ? buf_l_q : rep_l_q;
        rep_r_d = load & full_q ? buf_r_q : rep_r_q;
        full_d  = accept | (full_q & ~load);
        buf_l_d = accept ? APSDATA_LEFT_i : buf_l_q;
        buf_r_d = accept ? APSDATA_RIGHT_i : buf_r_q;
        und_d   = load & ~full_q;
        ovr_d   = accept & full_q & ~load;
        rb      = b_d - BW'(SLOT_W);
        ws_d    = fall ? (b_d >= BW'(SLOT_W - 1) && b_d <= BW'(FRAME - 2)) : ws_q;
        // a one-hot mask walks down each sample; outside the sample bits it shifts out to zero
        data_d  = fall ? (|(rep_l_d & (MSB >> b_d)) | |(rep_r_d & (MSB >> rb))) : data_q;
    end
    always_ff @(posedge AMCLK_i or posedge ARST) begin
        if (ARST) begin
            b_q     <= BW'(FRAME - 1);
            buf_l_q <= '0;
            buf_r_q <= '0;
            rep_l_q <= '0;
            rep_r_q <= '0;
            full_q  <= 1'b0;
            phase_q <= 1'b0;
            ws_q    <= 1'b0;
            data_q  <= 1'b0;
            und_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            b_q     <= b_d;
            buf_l_q <= buf_l_d;
            buf_r_q <= buf_r_d;
            rep_l_q <= rep_l_d;
            rep_r_q <= rep_r_d;
            full_q  <= full_d;
            phase_q <= phase_d;
            ws_q    <= ws_d;
            data_q  <= data_d;
            und_q   <= und_d;
            ovr_q   <= ovr_d;
        end
    end
    assign I2S_WS     = ws_q;
    assign I2S_DATA   = data_q;
    assign UNDERRUN_o = und_q;
    assign OVERRUN_o  = ovr_q;
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb_i2s_tx_serializer: scoreboard bench for the I2S transmitter
module tb_i2s_tx_serializer;
    import i2s_tx_serializer_pkg::*;
    localparam int SW = AUDIO_SAMPLE_W;
    localparam int SL = I2S_SLOT_W;
    localparam int D  = 2;
    localparam int FB = 2 * SL;
    localparam int FC = FB * 2 * D;
    localparam logic [FB-1:0] WS_EXP = {{(SL-1){1'b0}}, {SL{1'b1}}, 1'b0};
    typedef struct {
        logic [FB-1:0] data;
        logic          und;
    } frame_t;
    logic clk = 1'b0, rst = 1'b1;
    logic [SW-1:0] l_i = '0, r_i = '0;
    logic v_i = 1'b0, ds_i = 1'b0, ds_cur = 1'b0;
    logic bck, ws, sd, und, ovr;
    int unsigned cyc = 0;
    int checks = 0, errors = 0;
    frame_t fq[$];
    int unsigned oq[$];
    stereo_sample_t m_buf, m_rep;
    logic m_full, m_phase;
    logic [FB-1:0] dw, ww;
    int unsigned usee;
    frame_t f;
    i2s_tx_serializer #(.SAMPLE_W(SW), .SLOT_W(SL), .BCK_DIV(D)) dut (
        .AMCLK_i        (clk),
        .ARST           (rst),
        .APSDATA_LEFT_i (l_i),
        .APSDATA_RIGHT_i(r_i),
        .APDATA_VALID_i (v_i),
        .downsample_2x_i(ds_i),
        .I2S_BCK        (bck),
        .I2S_WS         (ws),
        .I2S_DATA       (sd),
        .UNDERRUN_o     (und),
        .OVERRUN_o      (ovr)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask
    function automatic logic is_load(input int unsigned n);
        return n >= 2 * D && (n - 2 * D) % FC == 0;
    endfunction
    function automatic logic [FB-1:0] frame_of(input stereo_sample_t p);
        return {p.left, {(SL-SW){1'b0}}, p.right, {(SL-SW){1'b0}}};
    endfunction
    task automatic step(input logic v, input logic [SW-1:0] l, input logic [SW-1:0] r, input logic ds);
        int unsigned n;
        logic acc;
        n = cyc + 1;
        v_i = v; l_i = l; r_i = r; ds_i = ds;
        acc = v && (!ds || !m_phase);
        if (!ds) m_phase = 1'b0;
        else if (v) m_phase = !m_phase;
        if (is_load(n)) begin
            fq.push_back('{frame_of(m_full ? m_buf : m_rep), !m_full});
            if (m_full) m_rep = m_buf;
            m_full = 1'b0;
        end
        if (acc) begin
            if (m_full) oq.push_back(n);
            m_buf = '{left: l, right: r};
            m_full = 1'b1;
        end
        @(negedge clk);
    endtask
    task automatic idle(input int k);
        repeat (k) step(1'b0, '0, '0, ds_cur);
    endtask
    task automatic to_phase(input int off);
        for (int i = 0; i < FC; i++) begin
            if (cyc + 1 >= 2 * D && (cyc + 1 - 2 * D) % FC == off) break;
            step(1'b0, '0, '0, ds_cur);
        end
    endtask
    task automatic do_reset();
        #1 rst = 1'b1;
        #1 check("async_reset", 64'({bck, ws, sd, und, ovr}), 64'(0));
        v_i = 1'b0;
        fq.delete();
        oq.delete();
        m_full = 1'b0; m_phase = 1'b0; m_buf = '0; m_rep = '0;
        repeat (3) @(negedge clk);
        check("reset_hold", 64'({bck, ws, sd, und, ovr}), 64'(0));
        rst = 1'b0;
    endtask
    always @(negedge clk) begin
        if (rst) begin
            usee = 0;
        end else begin
            check("bck", 64'(bck), 64'((cyc / D) % 2));
            if (und) usee++;
            if (ovr) begin
                if (oq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL overrun_spurious at cycle %0d: got 1 expected 0", cyc);
                end else check("overrun_cycle", 64'(cyc), 64'(oq.pop_front()));
            end
            if (oq.size() > 0 && oq[0] < cyc) begin
                checks++; errors++;
                $display("FAIL overrun_missing: got 0 expected pulse at cycle %0d", oq.pop_front());
            end
            if (cyc >= 3 * D && (cyc - D) % (2 * D) == 0) begin
                dw = {dw[FB-2:0], sd};
                ww = {ww[FB-2:0], ws};
                if (((cyc - 3 * D) / (2 * D)) % FB == FB - 1) begin
                    if (fq.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_missing at cycle %0d: got frame %h expected none", cyc, dw);
                    end else begin
                        f = fq.pop_front();
                        check("frame_data", 64'(dw), 64'(f.data));
                        check("frame_ws", 64'(ww), 64'(WS_EXP));
                        check("frame_underrun", 64'(usee), 64'(f.und));
                    end
                    usee = 0;
                end
            end
        end
    end
    initial begin
        m_full = 1'b0; m_phase = 1'b0; m_buf = '0; m_rep = '0;
        dw = '0; ww = '0; usee = 0;
        do_reset();
        idle(600);
        step(1'b1, 24'h800001, 24'h7FFFFF, 1'b0);
        idle(600);
        to_phase(20);
        step(1'b1, 24'h123456, 24'h654321, 1'b0);
        idle(9);
        step(1'b1, 24'hA5A5A5, 24'h5A5A5A, 1'b0);
        idle(300);
        ds_cur = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            to_phase(30);
            step(1'b1, SW'(k), SW'(k + 100), 1'b1);
        end
        to_phase(30);
        step(1'b1, SW'(6), SW'(106), 1'b1);
        ds_cur = 1'b0;
        to_phase(30);
        step(1'b1, SW'(7), SW'(107), 1'b0);
        idle(300);
        to_phase(30);
        step(1'b1, 24'hC0FFEE, 24'hBEEF01, 1'b0);
        to_phase(0);
        step(1'b1, 24'h0F0F0F, 24'hF0F0F0, 1'b0);
        idle(600);
        for (int i = 0; i < 25; i++) begin
            ds_cur = $urandom_range(0, 3) == 0;
            step(1'b1, SW'($urandom), SW'($urandom), ds_cur);
            idle($urandom_range(1, 300));
        end
        ds_cur = 1'b0;
        idle(300);
        to_phase(161);
        check("ws_right_slot", 64'(ws), 64'(1));
        do_reset();
        step(1'b1, 24'h7FFFFF, 24'h800000, 1'b0);
        idle(600);
        for (int i = 0; i < 600; i++) begin
            if (fq.size() == 0) break;
            step(1'b0, '0, '0, 1'b0);
        end
        check("drain_frames", 64'(fq.size()), 64'(0));
        check("drain_overruns", 64'(oq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- Parallel-to-I2S transmitter, the counterpart of the I2S receiver front end of the audio upsampling chain.
- Takes stereo PCM words with a valid strobe from the interpolator output and holds one pair in a single-entry buffer.
- Generates I2S bit clock, word select and serial data (Philips format) from AMCLK_i by integer division.
- Feeds the HDMI transmitter audio input.

Parameters:
- SAMPLE_W, 24, input sample width in bits (2..SLOT_W).
- SLOT_W, 32, BCK cycles per channel slot; frame = 2*SLOT_W BCK cycles.
- BCK_DIV, 4, AMCLK_i cycles per BCK half-period (>=1).

Ports:
- AMCLK_i  in  1  audio master clock; the only clock.
- ARST  in  1  asynchronous, active-high reset.
- APSDATA_LEFT_i  in  SAMPLE_W  left sample, two's complement.
- APSDATA_RIGHT_i  in  SAMPLE_W  right sample, two's complement.
- APDATA_VALID_i  in  1  one-cycle strobe; the L/R pair is valid this cycle.
- downsample_2x_i  in  1  1 = accept every second valid pair only.
- I2S_BCK  out  1  bit clock.
- I2S_WS  out  1  word select; 0 = left.
- I2S_DATA  out  1  serial data, MSB first.
- UNDERRUN_o  out  1  one-cycle pulse: frame started with empty buffer.
- OVERRUN_o  out  1  one-cycle pulse: accepted pair overwrote an unconsumed pair.

Behaviour:
Reset (ARST=1, async):
- I2S_BCK=0, I2S_WS=0, I2S_DATA=0, UNDERRUN_o=0, OVERRUN_o=0.
- div counter=0, bit index b=2*SLOT_W-1, buffer empty, shift/repeat registers=0, decimation phase=0.

BCK generation:
- div counter counts 0..BCK_DIV-1; at terminal count it wraps and I2S_BCK toggles.
- Falling event = terminal-count cycle while I2S_BCK=1.

On each falling event, registered so the outputs change together with BCK falling:
- b advances modulo 2*SLOT_W.
- I2S_WS=1 for new b in [SLOT_W-1, 2*SLOT_W-2], else 0. WS leads each slot by one BCK.
- I2S_DATA: left bit (SAMPLE_W-1-b) for b<SAMPLE_W; right bit (SAMPLE_W-1-(b-SLOT_W)) for SLOT_W<=b<SLOT_W+SAMPLE_W; 0 otherwise (zero padding).

Frame load (falling event where b wraps to 0):
- Buffer full: the L/R pair moves into the shift registers and the repeat register; buffer becomes empty.
- Buffer empty: the repeat register is re-sent and UNDERRUN_o pulses for 1 cycle.
- The first MSB appears 2*BCK_DIV cycles after reset release.

Input acceptance:
- downsample_2x_i=0: every APDATA_VALID_i is accepted; phase is held at 0.
- downsample_2x_i=1: phase toggles on each valid; a valid is accepted only when phase=0. The first valid after reset, or after the mode changes, is accepted.
- An accepted pair is written to the buffer, which becomes full.

Simultaneous events:
- Accept and frame load in the same cycle: the load consumes the old buffer content (or underruns if empty) and the new pair is stored. Buffer ends full. No overrun.
- Accept while full with no load: the pair is overwritten and OVERRUN_o pulses for 1 cycle.

Latency:
- An accepted pair is emitted at the next frame load.
- Worst case is 2*SLOT_W*2*BCK_DIV + 1 AMCLK_i cycles.

Reset mid-frame:
- Outputs are immediately at their reset values.
- The partial frame and the buffered pair are discarded.

Decomposition:
- Shared audio package: I2S_SLOT_W=32, AUDIO_SAMPLE_W=24 constants, and a stereo-sample struct {left, right}.
- One sub-module is natural: i2s_bck_gen (div counter, BCK toggle, falling-event strobe).
- Framing, buffer and shifting stay in the top module.

Test Plan:
- Reset/idle, BCK_DIV=2: no valid input -> BCK period 4 cycles; WS rises at b=31, falls at b=63; DATA=0; UNDERRUN_o pulses once per 256 cycles.
- Single pair L=0x800001, R=0x7FFFFF -> left slot bits 1000..0001 then 8 zeros; right slot 0111..1111 then 8 zeros; no flags.
- Starvation: one pair, then no input -> the same pair repeats in the next frame and UNDERRUN_o pulses once at that frame start.
- Overrun: two valids 10 cycles apart within one frame -> OVERRUN_o pulses on the second; the second pair is transmitted.
- downsample_2x_i=1: valids with L=1,2,3,4 -> only 1 and 3 are accepted; toggling the mode to 0 accepts the next valid.
- Load collision: valid on the exact frame-load cycle with a full buffer -> old pair sent, new pair sent in the following frame; no OVERRUN_o. Assert ARST mid-right-slot -> all outputs 0 within the same cycle.
